// File: rtl/irq_ctl.sv
// irq_ctl: interrupt controller front end for the processor control unit.
// Synchronizes the NMI/IRQ pins, latches NMI falling edges, and sequences
// RESET / IRQ / NMI vector selection for the control unit.
//
// Optional feature: define IRQ_CTL_NMI_EN to build NMI synchronizer, edge
// detection and pending latch. Without it, nmi_n is ignored and nmi_pend is 0.
//
// Ports:
//   clk       - clock, all state on rising edge
//   reset     - synchronous, active-high reset
//   nmi_n     - asynchronous NMI pin, active-low (edge-triggered)
//   irq_n     - asynchronous IRQ pin, active-low (level-sensitive)
//   I         - processor interrupt-disable flag
//   sync      - high while the control unit decodes the next opcode
//   vec_ack   - one-cycle pulse when the vector low byte is fetched
//   int_req   - interrupt request to the control unit
//   int_kind  - 00 none, 01 IRQ, 10 NMI, 11 RESET
//   vec_lo    - vector low byte
//   nmi_pend  - NMI latched and not yet taken
module irq_ctl (
   input  logic       clk,
   input  logic       reset,
   input  logic       nmi_n,
   input  logic       irq_n,
   input  logic       I,
   input  logic       sync,
   input  logic       vec_ack,
   output logic       int_req,
   output logic [1:0] int_kind,
   output logic [7:0] vec_lo,
   output logic       nmi_pend
);

   localparam int unsigned KIND_W = 2;
   localparam int unsigned VEC_W  = 8;

   localparam logic [KIND_W-1:0] KIND_NONE = KIND_W'(0);
   localparam logic [KIND_W-1:0] KIND_IRQ  = KIND_W'(1);
   localparam logic [KIND_W-1:0] KIND_NMI  = KIND_W'(2);
   localparam logic [KIND_W-1:0] KIND_RST  = KIND_W'(3);

   localparam logic [VEC_W-1:0] VEC_RST = VEC_W'(8'hFC);
   localparam logic [VEC_W-1:0] VEC_IRQ = VEC_W'(8'hFE);
   localparam logic [VEC_W-1:0] VEC_NMI = VEC_W'(8'hFA);

   typedef enum logic [1:0] {
      ST_RST  = 2'd0,
      ST_IDLE = 2'd1,
      ST_SVC  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              irq_s1_q, irq_s1_d;
   logic              irq_s2_q, irq_s2_d;
   logic              int_req_q, int_req_d;
   logic [KIND_W-1:0] int_kind_q, int_kind_d;
   logic [VEC_W-1:0]  vec_lo_q, vec_lo_d;
   logic              nmi_pend_w;
   logic              irq_act_c;

   // IRQ pin synchronizer; level is only qualified by the I flag
   always_comb begin
      irq_s1_d  = irq_n;
      irq_s2_d  = irq_s1_q;
      irq_act_c = ~irq_s2_q & ~I;
   end

`ifdef IRQ_CTL_NMI_EN
   logic nmi_s1_q, nmi_s1_d;
   logic nmi_s2_q, nmi_s2_d;
   logic nmi_prev_q, nmi_prev_d;
   logic nmi_pend_q, nmi_pend_d;
   logic nmi_edge_c;
   logic nmi_take_c;

   // NMI synchronizer, falling-edge detect and pending latch (set beats clear)
   always_comb begin
      nmi_s1_d   = nmi_n;
      nmi_s2_d   = nmi_s1_q;
      nmi_prev_d = nmi_s2_q;
      nmi_edge_c = nmi_prev_q & ~nmi_s2_q;
      nmi_take_c = (state_q == ST_IDLE) & sync & int_req_q & nmi_pend_q;
      nmi_pend_d = nmi_edge_c | (nmi_pend_q & ~nmi_take_c);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         nmi_s1_q   <= 1'b1;
         nmi_s2_q   <= 1'b1;
         nmi_prev_q <= 1'b1;
         nmi_pend_q <= 1'b0;
      end else begin
         nmi_s1_q   <= nmi_s1_d;
         nmi_s2_q   <= nmi_s2_d;
         nmi_prev_q <= nmi_prev_d;
         nmi_pend_q <= nmi_pend_d;
      end
   end

   assign nmi_pend_w = nmi_pend_q;
`else
   // NMI disabled: pin is deliberately left unconnected to any logic
   logic unused_nmi_n;
   assign unused_nmi_n = nmi_n;
   assign nmi_pend_w   = 1'b0;
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      int_req_d  = 1'b0;
      int_kind_d = int_kind_q;
      vec_lo_d   = vec_lo_q;
      unique case (state_q)
         ST_RST: begin
            int_kind_d = KIND_RST;
            vec_lo_d   = VEC_RST;
            if (vec_ack) begin
               state_d    = ST_IDLE;
               int_kind_d = KIND_NONE;
               vec_lo_d   = VEC_IRQ;
            end
         end
         ST_IDLE: begin
            int_req_d  = nmi_pend_w | irq_act_c;
            int_kind_d = KIND_NONE;
            vec_lo_d   = VEC_IRQ;
            // Take on the registered request so a dropped IRQ is not serviced
            if (sync && int_req_q) begin
               state_d   = ST_SVC;
               int_req_d = 1'b0;
               if (nmi_pend_w) begin
                  int_kind_d = KIND_NMI;
                  vec_lo_d   = VEC_NMI;
               end else begin
                  int_kind_d = KIND_IRQ;
                  vec_lo_d   = VEC_IRQ;
               end
            end
         end
         ST_SVC: begin
            if (vec_ack) begin
               state_d    = ST_IDLE;
               int_kind_d = KIND_NONE;
               vec_lo_d   = VEC_IRQ;
            end
         end
         default: begin
            state_d    = ST_RST;
            int_kind_d = KIND_RST;
            vec_lo_d   = VEC_RST;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_RST;
         irq_s1_q   <= 1'b1;
         irq_s2_q   <= 1'b1;
         int_req_q  <= 1'b0;
         int_kind_q <= KIND_RST;
         vec_lo_q   <= VEC_RST;
      end else begin
         state_q    <= state_d;
         irq_s1_q   <= irq_s1_d;
         irq_s2_q   <= irq_s2_d;
         int_req_q  <= int_req_d;
         int_kind_q <= int_kind_d;
         vec_lo_q   <= vec_lo_d;
      end
   end

   assign int_req  = int_req_q;
   assign int_kind = int_kind_q;
   assign vec_lo   = vec_lo_q;
   assign nmi_pend = nmi_pend_w;

endmodule

// File: tb/tb_irq_ctl.sv
// tb_irq_ctl: directed self-checking bench for irq_ctl.
module tb_irq_ctl;

   logic       clk;
   logic       reset;
   logic       nmi_n;
   logic       irq_n;
   logic       I;
   logic       sync;
   logic       vec_ack;
   logic       int_req;
   logic [1:0] int_kind;
   logic [7:0] vec_lo;
   logic       nmi_pend;

   int total;
   int bad;

   irq_ctl dut (
      .clk      (clk),
      .reset    (reset),
      .nmi_n    (nmi_n),
      .irq_n    (irq_n),
      .I        (I),
      .sync     (sync),
      .vec_ack  (vec_ack),
      .int_req  (int_req),
      .int_kind (int_kind),
      .vec_lo   (vec_lo),
      .nmi_pend (nmi_pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge, then settle 1 time unit before driving/sampling
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Check the three vector-facing outputs at once
   task automatic chk3(input string tag, input logic req, input logic [1:0] kind,
                       input logic [7:0] vec);
      chk({tag, "_req"}, 8'(int_req), 8'(req));
      chk({tag, "_kind"}, 8'(int_kind), 8'(kind));
      chk({tag, "_vec"}, vec_lo, vec);
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      reset   = 1'b1;
      nmi_n   = 1'b1;
      irq_n   = 1'b1;
      I       = 1'b0;
      sync    = 1'b0;
      vec_ack = 1'b0;

      // Reset and RESET vector phase
      step(2);
      chk3("reset", 1'b0, 2'b11, 8'hFC);
      chk("reset_pend", 8'(nmi_pend), 8'h00);
      reset = 1'b0;
      step(2);
      chk3("rst_hold", 1'b0, 2'b11, 8'hFC);
      vec_ack = 1'b1;
      step(1);
      chk3("rst_ack", 1'b0, 2'b00, 8'hFE);
      vec_ack = 1'b0;
      step(1);
      chk3("idle", 1'b0, 2'b00, 8'hFE);

      // vec_ack in IDLE is ignored
      vec_ack = 1'b1;
      step(1);
      vec_ack = 1'b0;
      chk3("idle_ack", 1'b0, 2'b00, 8'hFE);

      // IRQ latency: request visible after the third edge
      irq_n = 1'b0;
      step(2);
      chk("irq_lat2", 8'(int_req), 8'h00);
      step(1);
      chk3("irq_lat3", 1'b1, 2'b00, 8'hFE);
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      chk3("irq_take", 1'b0, 2'b01, 8'hFE);
      step(2);
      chk3("irq_svc_hold", 1'b0, 2'b01, 8'hFE);
      vec_ack = 1'b1;
      step(1);
      vec_ack = 1'b0;
      irq_n   = 1'b1;
      chk3("irq_ret", 1'b0, 2'b00, 8'hFE);
      step(4);
      chk3("irq_idle", 1'b0, 2'b00, 8'hFE);

      // Interrupt disable masks a held IRQ, even with sync pulsing
      I     = 1'b1;
      irq_n = 1'b0;
      for (int k = 0; k < 20; k++) begin
         sync = k[0];
         step(1);
         chk("mask_req", 8'(int_req), 8'h00);
         chk("mask_kind", 8'(int_kind), 8'h00);
      end
      sync  = 1'b0;
      irq_n = 1'b1;
      step(3);
      I = 1'b0;
      step(1);
      chk("mask_clear", 8'(int_req), 8'h00);

      // Short IRQ pulse without sync: request rises, falls, nothing taken
      irq_n = 1'b0;
      step(3);
      chk("pulse_rise", 8'(int_req), 8'h01);
      step(1);
      irq_n = 1'b1;
      step(2);
      chk("pulse_tail", 8'(int_req), 8'h01);
      step(1);
      chk3("pulse_fall", 1'b0, 2'b00, 8'hFE);
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      chk3("pulse_nosvc", 1'b0, 2'b00, 8'hFE);

      // Reset in the middle of service abandons it
      irq_n = 1'b0;
      step(3);
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      chk("mid_take", 8'(int_kind), 8'h01);
      reset = 1'b1;
      irq_n = 1'b1;
      step(1);
      chk3("mid_reset", 1'b0, 2'b11, 8'hFC);
      chk("mid_pend", 8'(nmi_pend), 8'h00);
      reset = 1'b0;
      step(1);
      chk3("mid_rst_hold", 1'b0, 2'b11, 8'hFC);
      vec_ack = 1'b1;
      step(1);
      vec_ack = 1'b0;
      chk3("mid_back", 1'b0, 2'b00, 8'hFE);
      step(3);

`ifdef IRQ_CTL_NMI_EN
      // NMI and IRQ together: NMI wins, then IRQ is taken
      nmi_n = 1'b0;
      irq_n = 1'b0;
      step(3);
      chk("nmi_pend_set", 8'(nmi_pend), 8'h01);
      chk("nmi_req", 8'(int_req), 8'h01);
      sync = 1'b1;
      step(1);
      sync  = 1'b0;
      nmi_n = 1'b1;
      chk3("nmi_take", 1'b0, 2'b10, 8'hFA);
      chk("nmi_pend_clr", 8'(nmi_pend), 8'h00);
      vec_ack = 1'b1;
      step(1);
      vec_ack = 1'b0;
      chk3("nmi_ret", 1'b0, 2'b00, 8'hFE);
      step(1);
      chk("nmi_irq_req", 8'(int_req), 8'h01);
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      chk3("nmi_then_irq", 1'b0, 2'b01, 8'hFE);

      // NMI edge during service is held, then serviced
      nmi_n = 1'b0;
      step(3);
      chk("svc_nmi_pend", 8'(nmi_pend), 8'h01);
      chk("svc_nmi_kind", 8'(int_kind), 8'h01);
      vec_ack = 1'b1;
      irq_n   = 1'b1;
      step(1);
      vec_ack = 1'b0;
      chk("svc_nmi_ret", 8'(int_kind), 8'h00);
      step(1);
      chk("svc_nmi_req", 8'(int_req), 8'h01);
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      chk3("svc_nmi_take", 1'b0, 2'b10, 8'hFA);
      chk("svc_nmi_clr", 8'(nmi_pend), 8'h00);
      vec_ack = 1'b1;
      step(1);
      vec_ack = 1'b0;
      nmi_n   = 1'b1;
      chk3("svc_nmi_done", 1'b0, 2'b00, 8'hFE);
`else
      // NMI disabled: pin has no effect
      nmi_n = 1'b0;
      step(5);
      chk("nonmi_pend", 8'(nmi_pend), 8'h00);
      chk("nonmi_req", 8'(int_req), 8'h00);
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      chk3("nonmi_kind", 1'b0, 2'b00, 8'hFE);
      nmi_n = 1'b1;
`endif
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit so the run always terminates
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/irq_ctl.md
IRQ_CTL -- requirements
Module: irq_ctl

Interface
REQ-001 The block SHALL have these ports, in order: clk input 1 (clock, all state on rising edge); reset input 1 (reset, synchronous, active-high); nmi_n input 1 (async NMI pin, active-low); irq_n input 1 (async IRQ pin, active-low); I input 1 (processor interrupt-disable flag); sync input 1 (high while the control unit decodes the next opcode); vec_ack input 1 (one-cycle pulse from the control unit when the vector low byte is fetched); int_req output 1 (interrupt request to the control unit); int_kind output 2 (00 none, 01 IRQ, 10 NMI, 11 RESET); vec_lo output 8 (vector low byte); nmi_pend output 1 (NMI latched and not yet taken).

Function
REQ-002 The block SHALL pass nmi_n and irq_n each through a two-flop synchronizer before any use.
REQ-003 The block SHALL detect an NMI edge as synchronized nmi_n going 1->0 between consecutive cycles, and SHALL set nmi_pend on that edge.
REQ-004 The block SHALL define irq_act as (synchronized irq_n == 0) & ~I; IRQ is level-sensitive and is never latched.
REQ-005 The block SHALL implement a state machine with states RST, IDLE and SVC.
REQ-006 In RST: int_kind = 11, vec_lo = 8'hFC, int_req = 0; on vec_ack the state SHALL go to IDLE.
REQ-007 In IDLE, int_req SHALL be a register loaded each cycle with nmi_pend | irq_act; int_kind = 00; vec_lo = 8'hFE (BRK/IRQ default).
REQ-008 In IDLE, when sync & int_req the block SHALL go to SVC and latch int_kind = 10 if nmi_pend, else 01; NMI has priority over IRQ.
REQ-009 When NMI is taken, nmi_pend SHALL clear in the same cycle; if a new NMI edge occurs in that same cycle, the set SHALL win.
REQ-010 In SVC: int_req = 0; vec_lo = 8'hFA for NMI or 8'hFE for IRQ; int_kind is held; on vec_ack the state SHALL go to IDLE with int_kind = 00.
REQ-011 NMI edges arriving in RST or SVC SHALL be latched in nmi_pend and serviced after the return to IDLE.
REQ-012 If irq_act drops before sync is seen, int_req SHALL drop one cycle later and no interrupt SHALL be taken.
REQ-013 vec_ack in IDLE SHALL be ignored.
REQ-014 Latency: irq_n falling at edge N (with I = 0) SHALL give int_req = 1 after edge N+3.

Reset
REQ-015 While reset is high at a clock edge, the block SHALL set state = RST, int_req = 0, int_kind = 11, vec_lo = 8'hFC, nmi_pend = 0, and both synchronizer chains to 1.
REQ-016 A reset asserted mid-service SHALL abandon SVC immediately and discard any latched NMI.

Configuration
REQ-017 With the macro IRQ_CTL_NMI_EN defined, NMI detection SHALL behave per REQ-003/009/011.
REQ-018 With IRQ_CTL_NMI_EN undefined, nmi_n SHALL be ignored, nmi_pend SHALL be tied to 0, int_kind 10 SHALL never occur, and no NMI synchronizer or edge logic SHALL be built.

Verification
REQ-019 Reset high 2 cycles, then low; vec_ack pulse at cycle 5 -> vec_lo = FC and int_kind = 11 until the pulse, then IDLE with int_kind = 00 and vec_lo = FE.
REQ-020 In IDLE with I = 0, irq_n low at cycle 10 and sync at cycle 15 -> int_req = 1 from cycle 13; int_kind = 01 from cycle 16; vec_lo = FE; vec_ack at cycle 20 returns to 00.
REQ-021 I = 1 with irq_n held low for 20 cycles and sync pulsing -> int_req stays 0 and no SVC entry.
REQ-022 nmi_n falling together with irq_n low, then sync -> int_kind = 10 and vec_lo = FA; after vec_ack, the next sync takes IRQ (int_kind = 01).
REQ-023 Second nmi_n falling edge during SVC -> nmi_pend = 1 is held; after vec_ack, the next sync takes NMI again.
REQ-024 irq_n pulsed low for 4 cycles with no sync -> int_req rises then falls, and the state stays IDLE.
